// File: rtl/i2c_temp_reader.sv
// Autonomous I2C master that polls an ADT7420-class temperature sensor and
// publishes the reading as an unsigned whole-degree Celsius byte.
module i2c_temp_reader #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h4B,
    parameter int         CLK_DIV_QTR = 125,
    parameter int         POLL_CYCLES = 50_000_000
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] temp_data,
    output logic       data_valid,
    output logic       ack_err,
    output logic       busy
);

    localparam int QW = $clog2(CLK_DIV_QTR);
    localparam int PW = $clog2(POLL_CYCLES + 1);

    localparam logic [QW-1:0] QTR_LAST  = QW'(CLK_DIV_QTR - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [7:0]    ADDR_BYTE = {SLAVE_ADDR, 1'b1};

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_START  = 4'd1;
    localparam logic [3:0] S_ADDR   = 4'd2;
    localparam logic [3:0] S_ACK_A  = 4'd3;
    localparam logic [3:0] S_RD_MSB = 4'd4;
    localparam logic [3:0] S_M_ACK  = 4'd5;
    localparam logic [3:0] S_RD_LSB = 4'd6;
    localparam logic [3:0] S_M_NACK = 4'd7;
    localparam logic [3:0] S_STOP   = 4'd8;

    logic [3:0]    r_state;
    logic [QW-1:0] r_qcnt;
    logic [1:0]    r_q;
    logic [2:0]    r_bit;
    logic [PW-1:0] r_poll;
    logic [15:0]   r_raw;
    logic          r_nack;
    logic          r_sda_oe;
    logic          r_scl_oe;
    logic          r_busy;
    logic [7:0]    r_temp;
    logic          r_valid;
    logic          r_ack_err;

    logic [3:0]    w_state_nxt;
    logic [QW-1:0] w_qcnt_nxt;
    logic [1:0]    w_q_nxt;
    logic [2:0]    w_bit_nxt;
    logic [PW-1:0] w_poll_nxt;
    logic          w_tick;
    logic          w_slot_end;
    logic          w_sample;
    logic          w_txn_done;
    logic          w_sda_nxt;
    logic          w_scl_nxt;
    logic          w_data_scl;

    assign w_tick     = (r_state != S_IDLE) && (r_qcnt == QTR_LAST);
    assign w_slot_end = w_tick && (r_q == 2'd3);
    assign w_sample   = w_tick && (r_q == 2'd1);
    assign w_txn_done = (r_state == S_STOP) && w_slot_end;

    // Slot sequencing: quarters advance on each tick, states on the end of q3.
    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        w_q_nxt     = r_q;
        w_bit_nxt   = r_bit;
        w_poll_nxt  = r_poll;
        if (r_state == S_IDLE) begin
            if (r_poll == POLL_LAST) begin
                w_state_nxt = S_START;
                w_qcnt_nxt  = '0;
                w_q_nxt     = 2'd0;
            end else begin
                w_poll_nxt = r_poll + 1'b1;
            end
        end else if (w_tick) begin
            w_qcnt_nxt = '0;
            w_q_nxt    = r_q + 2'd1;
            if (w_slot_end) begin
                case (r_state)
                    S_START: begin
                        w_state_nxt = S_ADDR;
                        w_bit_nxt   = 3'd7;
                    end
                    S_ADDR: begin
                        if (r_bit == 3'd0) begin
                            w_state_nxt = S_ACK_A;
                        end else begin
                            w_bit_nxt = r_bit - 3'd1;
                        end
                    end
                    S_ACK_A: begin
                        if (r_nack) begin
                            w_state_nxt = S_STOP;
                        end else begin
                            w_state_nxt = S_RD_MSB;
                            w_bit_nxt   = 3'd7;
                        end
                    end
                    S_RD_MSB: begin
                        if (r_bit == 3'd0) begin
                            w_state_nxt = S_M_ACK;
                        end else begin
                            w_bit_nxt = r_bit - 3'd1;
                        end
                    end
                    S_M_ACK: begin
                        w_state_nxt = S_RD_LSB;
                        w_bit_nxt   = 3'd7;
                    end
                    S_RD_LSB: begin
                        if (r_bit == 3'd0) begin
                            w_state_nxt = S_M_NACK;
                        end else begin
                            w_bit_nxt = r_bit - 3'd1;
                        end
                    end
                    S_M_NACK: w_state_nxt = S_STOP;
                    S_STOP: begin
                        w_state_nxt = S_IDLE;
                        w_poll_nxt  = '0;
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end else begin
            w_qcnt_nxt = r_qcnt + 1'b1;
        end
    end

    // Pad drive is decoded from the next state so the pads come straight off flops.
    always_comb begin
        w_sda_nxt  = 1'b0;
        w_scl_nxt  = 1'b0;
        w_data_scl = (w_q_nxt == 2'd0) || (w_q_nxt == 2'd3);
        case (w_state_nxt)
            S_START: begin
                w_sda_nxt = w_q_nxt[1];
                w_scl_nxt = (w_q_nxt == 2'd3);
            end
            S_ADDR: begin
                w_sda_nxt = ~ADDR_BYTE[w_bit_nxt];
                w_scl_nxt = w_data_scl;
            end
            S_M_ACK: begin
                w_sda_nxt = 1'b1;
                w_scl_nxt = w_data_scl;
            end
            S_ACK_A, S_RD_MSB, S_RD_LSB, S_M_NACK: begin
                w_scl_nxt = w_data_scl;
            end
            S_STOP: begin
                w_sda_nxt = ~w_q_nxt[1];
                w_scl_nxt = (w_q_nxt == 2'd0);
            end
            default: begin
                w_sda_nxt = 1'b0;
                w_scl_nxt = 1'b0;
            end
        endcase
    end

    // Poll counter is preloaded so the first START follows reset release immediately.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_qcnt   <= '0;
            r_q      <= 2'd0;
            r_bit    <= 3'd0;
            r_poll   <= POLL_LAST;
            r_sda_oe <= 1'b0;
            r_scl_oe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_qcnt   <= w_qcnt_nxt;
            r_q      <= w_q_nxt;
            r_bit    <= w_bit_nxt;
            r_poll   <= w_poll_nxt;
            r_sda_oe <= w_sda_nxt;
            r_scl_oe <= w_scl_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_raw     <= 16'd0;
            r_nack    <= 1'b0;
            r_temp    <= 8'd0;
            r_valid   <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if ((r_state == S_IDLE) && (w_state_nxt == S_START)) begin
                r_nack <= 1'b0;
            end
            if (w_sample) begin
                case (r_state)
                    S_ACK_A: begin
                        r_nack <= sda_i;
                        if (sda_i) begin
                            r_ack_err <= 1'b1;
                        end
                    end
                    S_RD_MSB, S_RD_LSB: r_raw <= {r_raw[14:0], sda_i};
                    default: r_raw <= r_raw;
                endcase
            end
            // raw[15:7] is the signed whole-degree value; negatives clamp to zero.
            if (w_txn_done && !r_nack) begin
                r_temp    <= r_raw[15] ? 8'd0 : r_raw[14:7];
                r_valid   <= 1'b1;
                r_ack_err <= 1'b0;
            end
        end
    end

    assign sda_oe     = r_sda_oe;
    assign scl_oe     = r_scl_oe;
    assign busy       = r_busy;
    assign temp_data  = r_temp;
    assign data_valid = r_valid;
    assign ack_err    = r_ack_err;

endmodule

// File: tb/tb_i2c_temp_reader.sv
// Bench for i2c_temp_reader: open-drain bus with an ADT7420-like slave model,
// a protocol monitor and a scoreboard checked at the end of every transaction.
`timescale 1ns/1ps
module tb_i2c_temp_reader;

    localparam int QTR      = 2;
    localparam int POLL     = 100;
    localparam int GOOD_LEN = 116 * QTR;
    localparam int NACK_LEN = 44 * QTR;

    typedef struct {
        bit         nack;
        logic [7:0] temp;
    } expEntry;

    logic       clk  = 1'b0;
    logic       rstN = 1'b0;
    logic       sdaOe;
    logic       sclOe;
    logic [7:0] tempData;
    logic       dataValid;
    logic       ackErr;
    logic       busy;
    logic       slvPull = 1'b0;

    wire busScl = ~sclOe;
    wire busSda = ~(sdaOe | slvPull);

    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;

    expEntry    expQ[$];
    logic [7:0] modelTemp = 8'd0;

    logic [15:0] slvData = 16'd0;
    bit          slvPresent = 1'b0;
    bit          acked = 1'b0;
    bit          inXfer = 1'b0;
    int          rcnt = 0;
    logic [7:0]  addrSh = 8'd0;
    int          startCondCyc = 0;

    bit          prevBusy = 1'b0;
    bit          haveStart = 1'b0;
    int          startCyc = 0;
    int          lastStart = 0;
    int          lastDur = 0;

    i2c_temp_reader #(
        .SLAVE_ADDR (7'h4B),
        .CLK_DIV_QTR(QTR),
        .POLL_CYCLES(POLL)
    ) dut (
        .clk_50MHz (clk),
        .rst_n     (rstN),
        .sda_i     (busSda),
        .sda_oe    (sdaOe),
        .scl_oe    (sclOe),
        .temp_data (tempData),
        .data_valid(dataValid),
        .ack_err   (ackErr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: event not allowed here (cycle %0d)", name, cyc);
    endtask

    // Raw register counts 1/128 degC (13-bit 1/16 degC value, left-justified).
    function automatic logic [7:0] refTemp(input logic [15:0] raw);
        int scaled;
        scaled = int'($signed(raw));
        if (scaled < 0) return 8'd0;
        return 8'(scaled / 128);
    endfunction

    task automatic applyStimulus(input logic [15:0] data, input bit present);
        expEntry e;
        slvData    = data;
        slvPresent = present;
        e.nack     = !present;
        if (present) modelTemp = refTemp(data);
        e.temp     = modelTemp;
        expQ.push_back(e);
    endtask

    task automatic waitTxnEnd();
        int n;
        n = 0;
        while (!busy && n < POLL + 20) begin
            @(negedge clk);
            n++;
        end
        if (!busy) reportFail("start_timeout");
        n = 0;
        while (busy && n < GOOD_LEN + 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) reportFail("stop_timeout");
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_sda_oe"}, int'(sdaOe), 0);
        checkOutput({tag, "_scl_oe"}, int'(sclOe), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_temp"}, int'(tempData), 0);
        checkOutput({tag, "_valid"}, int'(dataValid), 0);
        checkOutput({tag, "_ack_err"}, int'(ackErr), 0);
    endtask

    // Bus monitor: START/STOP are the only SDA edges allowed while SCL is high.
    always @(negedge busSda) begin
        if (rstN && busScl) begin
            if (inXfer) reportFail("sda_fall_while_scl_high");
            inXfer       = 1'b1;
            rcnt         = 0;
            addrSh       = 8'd0;
            acked        = 1'b0;
            startCondCyc = cyc;
        end
    end

    always @(posedge busSda) begin
        if (rstN && busScl) begin
            if (!inXfer || (rcnt != 10 && rcnt != 28)) begin
                reportFail("sda_rise_while_scl_high");
            end else begin
                // START-to-STOP edge spacing: 10 (NACK) or 28 slots of 4 quarters.
                checkOutput("stop_offset", cyc - startCondCyc, (rcnt == 10) ? 40 * QTR : 112 * QTR);
            end
            inXfer = 1'b0;
        end
    end

    always @(negedge rstN) begin
        inXfer  = 1'b0;
        slvPull = 1'b0;
        acked   = 1'b0;
    end

    always @(posedge busScl) begin
        if (rstN && inXfer) begin
            rcnt++;
            if (rcnt <= 8) addrSh = {addrSh[6:0], busSda};
            if (rcnt == 8) checkOutput("addr_byte", int'(addrSh), 8'h97);
            if (rcnt == 18) checkOutput("master_ack", int'(busSda), 0);
            if (rcnt == 27) checkOutput("master_nack", int'(busSda), 1);
        end
    end

    // Slave model drives SDA only just after SCL falls.
    always @(negedge busScl) begin
        if (rstN && inXfer) begin
            if (rcnt == 8 && slvPresent && addrSh == 8'h97) begin
                slvPull = 1'b1;
                acked   = 1'b1;
            end else if (acked && rcnt >= 9 && rcnt <= 16) begin
                slvPull = ~slvData[15 - (rcnt - 9)];
            end else if (acked && rcnt >= 18 && rcnt <= 25) begin
                slvPull = ~slvData[7 - (rcnt - 18)];
            end else begin
                slvPull = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every busy fall retires one expected transaction.
    always @(negedge clk) begin
        if (!rstN) begin
            prevBusy  = 1'b0;
            haveStart = 1'b0;
        end else begin
            if (busy && !prevBusy) begin
                if (haveStart) checkOutput("start_gap", cyc - lastStart, lastDur + POLL);
                startCyc = cyc;
            end
            if (!busy && prevBusy) begin
                if (expQ.size() == 0) begin
                    reportFail("unexpected_txn");
                end else begin
                    expEntry e;
                    e = expQ.pop_front();
                    checkOutput("busy_len", cyc - startCyc, e.nack ? NACK_LEN : GOOD_LEN);
                    checkOutput("data_valid", int'(dataValid), e.nack ? 0 : 1);
                    checkOutput("temp_data", int'(tempData), int'(e.temp));
                    checkOutput("ack_err", int'(ackErr), e.nack ? 1 : 0);
                    lastStart = startCyc;
                    lastDur   = e.nack ? NACK_LEN : GOOD_LEN;
                    haveStart = 1'b1;
                end
            end else if (dataValid) begin
                reportFail("stray_data_valid");
            end
            prevBusy = busy;
        end
    end

    initial begin
        int n;
        $display("[TB] start");
        applyStimulus(16'h0C80, 1'b1);
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rstN = 1'b1;
        @(posedge clk);
        #1 checkOutput("start_after_reset", int'(busy), 1);
        waitTxnEnd();

        applyStimulus(16'hFF80, 1'b1);
        waitTxnEnd();
        applyStimulus(16'h31FF, 1'b1);
        waitTxnEnd();
        applyStimulus(16'h0000, 1'b0);
        waitTxnEnd();
        applyStimulus(16'h0C80, 1'b1);
        waitTxnEnd();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(16'($urandom), ($urandom_range(0, 3) != 0));
            waitTxnEnd();
        end

        // Abort a transaction while the MSB is being read.
        applyStimulus(16'h1680, 1'b1);
        n = 0;
        while (!(busy && inXfer && rcnt >= 12) && n < POLL + GOOD_LEN) begin
            @(negedge clk);
            n++;
        end
        if (!(busy && inXfer && rcnt >= 12)) reportFail("rd_msb_timeout");
        @(posedge clk);
        #3 rstN = 1'b0;
        expQ.delete();
        modelTemp = 8'd0;
        #1 checkResetState("mid_reset");
        repeat (2) @(negedge clk);
        applyStimulus(16'h1680, 1'b1);
        rstN = 1'b1;
        @(posedge clk);
        #1 checkOutput("start_after_mid_reset", int'(busy), 1);
        waitTxnEnd();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
